// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the sequential restoring divider.
//   - state_t      : divider control states (IDLE, CALC, FIX)
//   - MAX_WIDTH    : widest operand the helpers below can handle
//   - DBZ_FILL     : quotient fill pattern reported on divide-by-zero
//   - cond_negate  : two's-complement negate when 'negate' is set
//
//   The helper works on MAX_WIDTH bits so it can serve any divider width;
//   callers zero-extend their operand with a size cast and truncate the
//   result back, which yields the correct WIDTH-bit two's complement.

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  localparam logic [MAX_WIDTH-1:0] DBZ_FILL = '1;

  function automatic logic [MAX_WIDTH-1:0] cond_negate(
    input logic [MAX_WIDTH-1:0] value,
    input logic                 negate
  );
    return negate ? ((~value) + MAX_WIDTH'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division iteration.
//   Ports:
//     rem_in  [WIDTH-1:0] : partial remainder before this step
//     dvd_bit             : next dividend bit shifted into the remainder
//     dvs     [WIDTH-1:0] : divisor magnitude (nonzero)
//     rem_out [WIDTH-1:0] : partial remainder after this step
//     q_bit               : quotient bit produced by this step

module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder is always below the divisor, so the shifted value is
  // below 2*dvs and WIDTH+1 bits hold the trial difference; its top bit
  // is therefore a reliable "went negative" indicator.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {1'b0, dvs};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring divider retiring one quotient bit per clock.
//   Supports unsigned and two's-complement operands, reports quotient and
//   remainder, and flags divide-by-zero and signed overflow.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     start                : request a division (accepted only in IDLE)
//     signed_mode          : 1 = two's-complement operands
//     dividend, divisor    : operands, sampled with an accepted start
//     busy                 : operation in progress
//     done                 : one-cycle pulse when results are valid
//     quotient, remainder  : results, held until the next completion
//     div_by_zero          : last operation had a zero divisor
//     overflow             : last operation was most-negative / -1
//   WIDTH must be in the range 2..MAX_WIDTH.

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic             accept;
  logic             iterate;
  logic             finish;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // Operand conditioning at start: only signed operands with the MSB set
  // are negated. The most-negative value negates to itself, which read as
  // unsigned is exactly its magnitude.
  always_comb begin
    dvd_neg  = signed_mode & dividend[WIDTH-1];
    dvs_neg  = signed_mode & divisor[WIDTH-1];
    dvs_zero = (divisor == '0);
    abs_dvd  = WIDTH'(cond_negate(MAX_WIDTH'(dividend), dvd_neg));
    abs_dvs  = WIDTH'(cond_negate(MAX_WIDTH'(divisor), dvs_neg));
  end

  // Result correction. dvd_q has been shifted full of quotient bits by the
  // time FIX is reached; on divide-by-zero it still holds the raw dividend.
  always_comb begin
    q_fix = dbz_q ? WIDTH'(DBZ_FILL)
                  : WIDTH'(cond_negate(MAX_WIDTH'(dvd_q), sign_q_q));
    r_fix = dbz_q ? dvd_q
                  : WIDTH'(cond_negate(MAX_WIDTH'(rem_q), sign_r_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter starts at WIDTH and CALC leaves on the edge that takes it
  // to zero, so exactly WIDTH iterations run before FIX.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = dvs_zero ? FIX : CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // A zero divisor skips CALC, so the raw dividend is kept for the
        // remainder and sign correction is suppressed.
        cnt_q       <= CNT_W'(WIDTH);
        rem_q       <= '0;
        dvd_q       <= dvs_zero ? dividend : abs_dvd;
        dvs_q       <= abs_dvs;
        sign_q_q    <= ~dvs_zero & (dvd_neg ^ dvs_neg);
        sign_r_q    <= ~dvs_zero & dvd_neg;
        dbz_q       <= dvs_zero;
        ovf_q       <= signed_mode & (dividend == MOST_NEG) & (divisor == '1);
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end else if (iterate) begin
        rem_q <= step_rem;
        dvd_q <= {dvd_q[WIDTH-2:0], step_qbit};
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (finish) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= dbz_q;
        overflow    <= ovf_q;
        done        <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule
